// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
//
// Purpose:
//   SPI (mode 0) slave that turns serial transactions into single-cycle
//   register-bus strobes. Every transfer starts with a command byte, sent
//   MSB first. Bit 7 of the command selects write (1) or read (0), and the
//   low ADDR_W bits give the register address. One DATA_W-bit data word
//   follows. On a write the word is shifted in from MOSI and reg_wr pulses.
//   On a read reg_rd pulses, the returned reg_rdata is loaded into a
//   transmit shifter, and that shifter is driven MSB first on MISO.
//   All three SPI inputs are asynchronous. They are synchronized into clk,
//   and SCLK edges are recovered from the synchronized copy, so SCLK must
//   run at clk/6 or slower.
//
// Configuration macro:
//   SPI_REG_BRIDGE_BURST_EN
//     Defined     : the bridge stays in DATA after each word. Each word
//                   completed advances reg_addr by one, wrapping modulo
//                   2^ADDR_W. Writes keep issuing reg_wr. Reads prefetch
//                   the next word with reg_rd on the last falling SCLK edge
//                   of the current word.
//     Undefined   : after one data word the bridge parks in SKIP until
//                   chip select is released.
//
// Parameters:
//   ADDR_W      register address width (1..7)
//   DATA_W      register data width (8, 16 or 32)
//   SYNC_STAGES synchronizer depth for the SPI inputs (>= 2)
//
// Ports:
//   clk          system clock; all state changes on its rising edge
//   rst          asynchronous active-high reset
//   spi_cs_n     raw chip select, active low
//   spi_clk      raw SPI clock (mode 0)
//   spi_mosi     raw serial data in
//   spi_miso     serial data out (0 whenever not driven)
//   spi_miso_oe  MISO drive enable
//   reg_addr     register address
//   reg_wdata    register write data
//   reg_wr       one-cycle write strobe
//   reg_rd       one-cycle read request
//   reg_rdata    read data, valid the cycle after reg_rd
// -----------------------------------------------------------------------------
module spi_reg_bridge #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_SKIP = 2'd3;

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Input synchronizers. Index 0 is the first flop and
    // SYNC_STAGES-1 is the output. The reset value is 0, so the
    // synchronized chip select reads "low" straight after reset. A
    // falling edge can then only be seen after the pin has been high,
    // which means a transfer already in progress at reset release is
    // ignored.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    logic w_cs;
    logic w_sclk;
    logic w_mosi;

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge detection on the synchronized signals
    // ------------------------------------------------------------------
    logic r_cs_prev;
    logic r_sclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
        end
    end

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_rise;
    logic w_sclk_fall;

    assign w_cs_fall   =  r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev &  w_cs;
    // SCLK activity only counts while the device is selected
    assign w_sclk_rise = ~r_sclk_prev &  w_sclk & ~w_cs;
    assign w_sclk_fall =  r_sclk_prev & ~w_sclk & ~w_cs;

    // ------------------------------------------------------------------
    // Datapath and FSM registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [6:0]        r_cmd;        // first seven command bits
    logic [DATA_W-2:0] r_rx;         // write word, all but the final bit
    logic [DATA_W-1:0] r_tx;         // read word being shifted out
    logic              r_is_read;
    logic              r_half;       // a data rising edge has been seen;
                                     // the next falling edge shifts
    logic              r_load;       // reg_rdata is valid this cycle
    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_reg_wdata;
    logic              r_reg_wr;
    logic              r_reg_rd;
`ifdef SPI_REG_BRIDGE_BURST_EN
    logic              r_addr_inc;   // advance address after a burst write
`endif

    // The address is taken from the current command bits plus the bit
    // arriving now, so it is ready on the 8th rising edge.
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_cmd_write;

    generate
        if (ADDR_W == 1) begin : g_addr_one
            assign w_cmd_addr = w_mosi;
        end else begin : g_addr_multi
            assign w_cmd_addr = {r_cmd[ADDR_W-2:0], w_mosi};
        end
    endgenerate

    assign w_cmd_write = r_cmd[6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_cmd       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_is_read   <= 1'b0;
            r_half      <= 1'b0;
            r_load      <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
`ifdef SPI_REG_BRIDGE_BURST_EN
            r_addr_inc  <= 1'b0;
`endif
        end else begin
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            r_load   <= r_reg_rd;
`ifdef SPI_REG_BRIDGE_BURST_EN
            r_addr_inc <= 1'b0;
            if (r_addr_inc) begin
                r_reg_addr <= r_reg_addr + ADDR_W'(1);
            end
`endif

            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= S_CMD;
                        r_bit_cnt <= '0;
                        r_cmd     <= '0;
                        r_rx      <= '0;
                        r_tx      <= '0;
                        r_is_read <= 1'b0;
                        r_half    <= 1'b0;
                    end
                end

                S_CMD: begin
                    if (w_cs_rise) begin
                        // A partial command byte is dropped silently
                        r_state <= S_IDLE;
                    end else if (w_sclk_rise) begin
                        r_cmd <= {r_cmd[5:0], w_mosi};
                        if (r_bit_cnt == CMD_LAST) begin
                            r_reg_addr <= w_cmd_addr;
                            r_is_read  <= ~w_cmd_write;
                            r_reg_rd   <= ~w_cmd_write;
                            r_bit_cnt  <= '0;
                            r_half     <= 1'b0;
                            r_state    <= S_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (w_cs_rise) begin
                        // A partial word is dropped; no strobe is issued
                        r_state <= S_IDLE;
                    end else if (r_is_read) begin
                        // The falling edge that ends the command byte
                        // arrives before any data rising edge. r_half
                        // keeps that edge from shifting the word.
                        if (w_sclk_rise) begin
                            r_half <= 1'b1;
                        end else if (w_sclk_fall && r_half) begin
                            r_half <= 1'b0;
                            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt <= '0;
`ifdef SPI_REG_BRIDGE_BURST_EN
                                r_reg_addr <= r_reg_addr + ADDR_W'(1);
                                r_reg_rd   <= 1'b1;
`else
                                r_state <= S_SKIP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end else if (w_sclk_rise) begin
                        r_rx <= {r_rx[DATA_W-3:0], w_mosi};
                        if (r_bit_cnt == DATA_LAST) begin
                            r_reg_wdata <= {r_rx, w_mosi};
                            r_reg_wr    <= 1'b1;
                            r_bit_cnt   <= '0;
`ifdef SPI_REG_BRIDGE_BURST_EN
                            r_addr_inc <= 1'b1;
`else
                            r_state <= S_SKIP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                S_SKIP: begin
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase

            // The read word is captured one cycle after reg_rd. It takes
            // priority over any shift, because the old word has been
            // fully sent by then.
            if (r_load && (r_state == S_DATA) && r_is_read && !w_cs_rise) begin
                r_tx <= reg_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_oe;

    assign w_oe        = (r_state == S_DATA) && r_is_read && !w_cs;
    assign spi_miso_oe = w_oe;
    assign spi_miso    = w_oe & r_tx[DATA_W-1];
    assign reg_addr    = r_reg_addr;
    assign reg_wdata   = r_reg_wdata;
    assign reg_wr      = r_reg_wr;
    assign reg_rd      = r_reg_rd;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
//
// Self-checking bench for spi_reg_bridge (ADDR_W=4, DATA_W=8). A register
// file model answers reg_rd. Every reg_wr and reg_rd is logged. Each
// transfer is checked against the strobe list and MISO words that the
// transaction rules predict. The bench follows SPI_REG_BRIDGE_BURST_EN,
// so it can be built with or without the macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_reg_bridge;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int HALF = 8;   // SCLK half period in clk cycles

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          spi_cs_n = 1'b1;
    logic          spi_clk  = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_wr;
    logic          reg_rd;
    logic [DW-1:0] reg_rdata = '0;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [16];
    logic [31:0]   wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [31:0]   rd_addr_q[$];
    int            both_cnt = 0;

    logic [31:0] txw [4];
    logic [31:0] rxw [4];
    logic        oe_cmd;
    logic        oe_first;
    logic [31:0] scratch;
    logic        s_any;
    logic        s_all;

    always #5 clk = ~clk;

    spi_reg_bridge #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_cs_n   (spi_cs_n),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata)
    );

    // Register file: read data is valid the cycle after reg_rd
    always @(posedge clk) begin
        if (reg_rd) reg_rdata <= mem[reg_addr];
    end

    // Strobe logger, sampled away from the active edge
    always @(negedge clk) begin
        if (reg_wr) begin
            wr_addr_q.push_back(32'(reg_addr));
            wr_data_q.push_back(32'(reg_wdata));
        end
        if (reg_rd) rd_addr_q.push_back(32'(reg_addr));
        if (reg_wr && reg_rd) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends nbits of w, MSB first. MISO is sampled on each rising SCLK edge.
    task automatic spi_word(input logic [31:0] w, input int nbits,
                            output logic [31:0] rx, output logic oe_any,
                            output logic oe_all);
        rx     = '0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = w[i];
            tick(HALF);
            spi_clk = 1'b1;
            rx      = {rx[30:0], spi_miso};
            oe_any  = oe_any | spi_miso_oe;
            oe_all  = oe_all & spi_miso_oe;
            tick(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    // Sends a complete transfer: the command byte, then nwords data words
    // taken from txw. The MISO words received are stored in rxw.
    task automatic xfer(input logic [7:0] cmd, input int nwords);
        clear_logs();
        spi_cs_n = 1'b0;
        tick(HALF);
        spi_word(32'(cmd), 8, scratch, oe_cmd, s_all);
        oe_first = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            spi_word(txw[k], DW, rxw[k], s_any, s_all);
            if (k == 0) oe_first = s_all;
        end
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(4 * HALF);
    endtask

    // Reference rules: how many data words a transfer of n words acts on
    function automatic int words_taken(input int n);
`ifdef SPI_REG_BRIDGE_BURST_EN
        return n;
`else
        return (n > 0) ? 1 : 0;
`endif
    endfunction

    task automatic expect_writes(input string tag, input int a, input int n);
        int en;
        en = words_taken(n);
        check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(en));
        check({tag, "_rd_count"}, 32'(rd_addr_q.size()), 32'd0);
        for (int i = 0; i < en && i < wr_addr_q.size(); i++) begin
            check({tag, "_wr_addr"}, wr_addr_q[i], 32'((a + i) % 16));
            check({tag, "_wr_data"}, wr_data_q[i], txw[i] & 32'hFF);
        end
    endtask

    task automatic expect_reads(input string tag, input int a, input int n);
        int nrd;
        logic [31:0] exp_word;
`ifdef SPI_REG_BRIDGE_BURST_EN
        nrd = n + 1;   // the last word also prefetches the next register
`else
        nrd = 1;
`endif
        check({tag, "_rd_count"}, 32'(rd_addr_q.size()), 32'(nrd));
        check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'd0);
        for (int i = 0; i < nrd && i < rd_addr_q.size(); i++)
            check({tag, "_rd_addr"}, rd_addr_q[i], 32'((a + i) % 16));
        for (int i = 0; i < n; i++) begin
            exp_word = (i < words_taken(n)) ? 32'(mem[(a + i) % 16]) : 32'd0;
            check({tag, "_miso_word"}, rxw[i], exp_word);
        end
        check({tag, "_oe_cmd"}, 32'(oe_cmd), 32'd0);
        check({tag, "_oe_data"}, 32'(oe_first), 32'd1);
    endtask

    task automatic expect_idle_outputs(input string tag);
        check({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
        check({tag, "_miso"}, 32'(spi_miso), 32'd0);
    endtask

    initial begin
        int a, n;
        logic w;
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);

        // Reset state
        tick(5);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_wr", 32'(reg_wr), 32'd0);
        check("rst_rd", 32'(reg_rd), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        rst = 1'b0;
        tick(10);

        // Single write: command 0x83, data 0xA5
        txw[0] = 32'hA5;
        xfer(8'h83, 1);
        expect_writes("wr83", 3, 1);
        expect_idle_outputs("wr83_after");

        // Single read: command 0x05, register holds 0x3C
        mem[5] = 8'h3C;
        xfer(8'h05, 1);
        expect_reads("rd05", 5, 1);
        expect_idle_outputs("rd05_after");

        // Write aborted after 5 data bits, then a normal write
        clear_logs();
        spi_cs_n = 1'b0;
        tick(HALF);
        spi_word(32'h81, 8, scratch, s_any, s_all);
        spi_word(32'h1F, 5, scratch, s_any, s_all);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(4 * HALF);
        check("abort_wr_count", 32'(wr_addr_q.size()), 32'd0);
        txw[0] = 32'h11;
        xfer(8'h82, 1);
        expect_writes("wr82", 2, 1);

        // Partial read command gives no reg_rd
        clear_logs();
        spi_cs_n = 1'b0;
        tick(HALF);
        spi_word(32'h0, 3, scratch, s_any, s_all);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(4 * HALF);
        check("partial_cmd_rd_count", 32'(rd_addr_q.size()), 32'd0);

        // Two words at address 15: with burst the address wraps to 0
        txw[0] = 32'h01;
        txw[1] = 32'h02;
        xfer(8'h8F, 2);
        expect_writes("wr8F", 15, 2);

        // Randomized transfers against the reference rules
        for (int t = 0; t < 8; t++) begin
            w = 1'($urandom);
            a = int'($urandom_range(0, 15));
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) txw[k] = 32'($urandom) & 32'hFF;
            for (int k = 0; k < 16; k++) mem[k] = DW'($urandom);
            xfer({w, 3'($urandom), 4'(a)}, n);
            $display("[TB] xfer %0d: %s addr=%0d words=%0d", t, w ? "write" : "read", a, n);
            if (w) expect_writes("rand_wr", a, n);
            else   expect_reads("rand_rd", a, n);
        end

        // Reset pulsed during the 4th data bit of a write
        clear_logs();
        spi_cs_n = 1'b0;
        tick(HALF);
        spi_word(32'h84, 8, scratch, s_any, s_all);
        spi_word(32'h5, 3, scratch, s_any, s_all);
        spi_mosi = 1'b1;
        tick(HALF / 2);
        rst = 1'b1;
        tick(2);
        check("midrst_addr", 32'(reg_addr), 32'd0);
        check("midrst_wdata", 32'(reg_wdata), 32'd0);
        check("midrst_strobes", 32'({reg_wr, reg_rd}), 32'd0);
        check("midrst_miso", 32'({spi_miso, spi_miso_oe}), 32'd0);
        rst = 1'b0;
        tick(HALF / 2);
        spi_clk = 1'b1;
        tick(HALF);
        spi_clk = 1'b0;
        spi_word(32'hA, 4, scratch, s_any, s_all);
        // A whole transaction with chip select still low must be ignored
        spi_word(32'h86, 8, scratch, s_any, s_all);
        spi_word(32'h5A, 8, scratch, s_any, s_all);
        tick(HALF);
        check("postrst_wr_count", 32'(wr_addr_q.size()), 32'd0);
        check("postrst_rd_count", 32'(rd_addr_q.size()), 32'd0);
        spi_cs_n = 1'b1;
        tick(4 * HALF);
        txw[0] = 32'h5A;
        xfer(8'h86, 1);
        expect_writes("wr86", 6, 1);

        check("wr_rd_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
